tx_frame_sequencer: RTL
=======================

Name: tx_frame_sequencer

Overview:
Per-frame controller for the 10G MAC transmit engine byte counter. It accepts client words on the 64-bit (8-byte-lane) datapath and drives the counter's start, parallel-count and clear controls. It also sequences the datapath through pad, CRC-append and inter-frame-gap phases, and flags underrun and oversize frames. It sits between the client handshake and the tx datapath/counter pair.

Parameters:
MIN_LEN, 60, minimum frame bytes excluding FCS; pad target.
MAX_LEN, 1514, maximum frame bytes excluding FCS; legal range 60..65527.
IFG_CYCLES, 2, idle cycles after CRC or abort; legal range 1..255.

Ports:
CLK  in  1  clock
RESET  in  1  async active-high reset
TX_START  in  1  client frame request, level
TX_ACK  out  1  one-cycle grant pulse
TX_DATA_VALID  in  1  word present this cycle (DATA state)
TX_LAST  in  1  current word is final
TX_LAST_BYTES  in  3  valid bytes in final word; 0 means 8
TX_READY  out  1  sequencer accepts a word this cycle
BYTE_COUNTER  in  16  current count from byte counter
CNT_START  out  1  counter increment enable
CNT_PARALLEL  out  1  1 = +8, 0 = +1
CNT_CLR  out  1  synchronous counter clear pulse (ORed into counter reset by parent)
PAD_EN  out  1  datapath inserts zero bytes
CRC_EN  out  1  datapath appends FCS
FRAME_DONE  out  1  pulse, good frame completed
ERR_UNDERRUN  out  1  pulse
ERR_OVERSIZE  out  1  pulse
BUSY  out  1  state != IDLE

Behaviour:
- Reset is RESET, asynchronous, active-high; clock is CLK.
- On RESET: state = IDLE, tail counter = 0, IFG counter = 0, and every output = 0.
- RESET asserted mid-frame aborts with no error pulse.
- TX_ACK, FRAME_DONE and the error pulses are registered.
- CNT_START, CNT_PARALLEL, TX_READY, PAD_EN and CRC_EN are combinational from state and inputs. The counter therefore updates on the same edge as the word transfer.
- All length comparisons use 17-bit arithmetic; no wrap.
- States: IDLE, ACK, DATA, TAIL, PAD, CRC, IFG.
- IDLE:
  - TX_START=1 -> ACK.
  - TX_START in any other state is ignored.
- ACK: TX_ACK=1 for exactly one cycle -> DATA.
- DATA: TX_READY=1.
  - Valid word with BYTE_COUNTER+8 > MAX_LEN: ERR_OVERSIZE next cycle; word not counted -> IFG. Oversize has priority over last.
  - Valid, not last: CNT_START=1, CNT_PARALLEL=1.
  - Valid, last, LAST_BYTES=0: +8 -> PAD.
  - Valid, last, LAST_BYTES=k (1..7): no count; tail counter = k -> TAIL.
  - TX_DATA_VALID=0: ERR_UNDERRUN next cycle -> IFG; no pad, no CRC.
- TAIL:
  - TX_READY=0; CNT_START=1, CNT_PARALLEL=0 each cycle; tail counter decrements.
  - Exactly k cycles -> PAD.
- PAD:
  - BYTE_COUNTER+8 <= MIN_LEN: PAD_EN=1, +8, stay.
  - Else if BYTE_COUNTER < MIN_LEN: PAD_EN=1, +1, stay.
  - Else: no count -> CRC. One check cycle is always spent.
- CRC: CRC_EN=1 for one cycle; FRAME_DONE pulses next cycle -> IFG. FCS bytes are not counted.
- IFG:
  - Stay IFG_CYCLES cycles.
  - CNT_CLR=1 on the last IFG cycle -> IDLE.
  - BYTE_COUNTER reads 0 on the first IDLE cycle.
- Error and done pulses are mutually exclusive per frame.

Decomposition:
- Package tx_seq_pkg holds:
  - state enum;
  - LANE_BYTES=8;
  - default MIN_LEN/MAX_LEN constants;
  - 17-bit length type.
- Sub-module tx_ifg_timer (load/decrement/zero flag, 8-bit) is natural.
- The byte counter stays an external sibling instance.

Test Plan:
- 8-byte frame (one word, LAST_BYTES=0):
  - counter 8 after DATA;
  - PAD issues 6x(+8) then 4x(+1) -> 60, plus one check cycle;
  - CRC_EN one cycle, then FRAME_DONE;
  - CNT_CLR after 2 IFG cycles.
- 61-byte frame (7 full words + LAST_BYTES=5):
  - counter 56, then 5 TAIL cycles -> 61 with TX_READY=0;
  - PAD check only, no PAD_EN;
  - CRC, FRAME_DONE.
- 64-byte frame (8 full words): counter 64, PAD check cycle, CRC; no pad bytes.
- Underrun: TX_DATA_VALID=0 on word 3 -> counter holds 16, ERR_UNDERRUN pulse, no PAD_EN/CRC_EN, IFG then IDLE with counter 0.
- Oversize (MAX_LEN=64): 9 valid words -> word 9 rejected, counter 64, ERR_OVERSIZE pulse, no FRAME_DONE.
- RESET during PAD: all outputs 0 immediately, state IDLE. TX_START held during ACK/DATA/IFG produces exactly one TX_ACK per frame.

Source files
------------

// File: rtl/tx_frame_sequencer_pkg.sv
// Shared types and constants for the 10G MAC transmit frame sequencer.
// Lengths are held in 17 bits so that "count + one lane" can never wrap.
package tx_seq_pkg;

  localparam int LANE_BYTES     = 8;
  localparam int DEF_MIN_LEN    = 60;
  localparam int DEF_MAX_LEN    = 1514;
  localparam int DEF_IFG_CYCLES = 2;

  typedef logic [16:0] len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_DATA,
    ST_TAIL,
    ST_PAD,
    ST_CRC,
    ST_IFG
  } state_t;

  function automatic len_t to_len(input logic [15:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/tx_frame_sequencer_ifg_timer.sv
// Inter-frame-gap down counter: loaded on IFG entry, zero flags the last gap cycle.
module tx_ifg_timer (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != 8'd0)) begin
      count_d = count_q - 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == 8'd0);

endmodule

// File: rtl/tx_frame_sequencer.sv
// Per-frame transmit controller: client handshake, byte-counter controls,
// pad / FCS / inter-frame-gap sequencing and underrun / oversize flags.
module tx_frame_sequencer
  import tx_seq_pkg::*;
#(
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TX_START,
  output logic        TX_ACK,
  input  logic        TX_DATA_VALID,
  input  logic        TX_LAST,
  input  logic [2:0]  TX_LAST_BYTES,
  output logic        TX_READY,
  input  logic [15:0] BYTE_COUNTER,
  output logic        CNT_START,
  output logic        CNT_PARALLEL,
  output logic        CNT_CLR,
  output logic        PAD_EN,
  output logic        CRC_EN,
  output logic        FRAME_DONE,
  output logic        ERR_UNDERRUN,
  output logic        ERR_OVERSIZE,
  output logic        BUSY
);

  localparam len_t       MIN_LEN_L = len_t'(MIN_LEN);
  localparam len_t       MAX_LEN_L = len_t'(MAX_LEN);
  localparam len_t       LANE_L    = len_t'(LANE_BYTES);
  localparam logic [7:0] IFG_LOAD  = 8'(IFG_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] tail_q, tail_d;
  logic       tx_ack_q, tx_ack_d;
  logic       frame_done_q, frame_done_d;
  logic       err_underrun_q, err_underrun_d;
  logic       err_oversize_q, err_oversize_d;

  len_t count_len;
  len_t count_plus_lane;
  logic ifg_load;
  logic ifg_zero;

  assign count_len       = to_len(BYTE_COUNTER);
  assign count_plus_lane = count_len + LANE_L;

  always_comb begin
    state_d        = state_q;
    tail_d         = tail_q;
    tx_ack_d       = 1'b0;
    frame_done_d   = 1'b0;
    err_underrun_d = 1'b0;
    err_oversize_d = 1'b0;
    TX_READY       = 1'b0;
    CNT_START      = 1'b0;
    CNT_PARALLEL   = 1'b0;
    CNT_CLR        = 1'b0;
    PAD_EN         = 1'b0;
    CRC_EN         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (TX_START) begin
          tx_ack_d = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        TX_READY = 1'b1;
        if (!TX_DATA_VALID) begin
          err_underrun_d = 1'b1;
          state_d        = ST_IFG;
        end else if (count_plus_lane > MAX_LEN_L) begin
          // Rejected word is never counted, even when it is the last one.
          err_oversize_d = 1'b1;
          state_d        = ST_IFG;
        end else if (!TX_LAST || (TX_LAST_BYTES == 3'd0)) begin
          CNT_START    = 1'b1;
          CNT_PARALLEL = 1'b1;
          if (TX_LAST) begin
            state_d = ST_PAD;
          end
        end else begin
          tail_d  = TX_LAST_BYTES;
          state_d = ST_TAIL;
        end
      end
      ST_TAIL: begin
        CNT_START = 1'b1;
        tail_d    = tail_q - 3'd1;
        if (tail_q == 3'd1) begin
          state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        // Whole lanes while they fit under the minimum, then single bytes.
        if (count_plus_lane <= MIN_LEN_L) begin
          PAD_EN       = 1'b1;
          CNT_START    = 1'b1;
          CNT_PARALLEL = 1'b1;
        end else if (count_len < MIN_LEN_L) begin
          PAD_EN    = 1'b1;
          CNT_START = 1'b1;
        end else begin
          state_d = ST_CRC;
        end
      end
      ST_CRC: begin
        CRC_EN       = 1'b1;
        frame_done_d = 1'b1;
        state_d      = ST_IFG;
      end
      ST_IFG: begin
        if (ifg_zero) begin
          CNT_CLR = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= ST_IDLE;
      tail_q         <= '0;
      tx_ack_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      err_underrun_q <= 1'b0;
      err_oversize_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      tail_q         <= tail_d;
      tx_ack_q       <= tx_ack_d;
      frame_done_q   <= frame_done_d;
      err_underrun_q <= err_underrun_d;
      err_oversize_q <= err_oversize_d;
    end
  end

  assign ifg_load = (state_d == ST_IFG) && (state_q != ST_IFG);

  tx_ifg_timer u_ifg_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (ifg_load),
    .load_val (IFG_LOAD),
    .dec      (state_q == ST_IFG),
    .zero     (ifg_zero)
  );

  assign TX_ACK       = tx_ack_q;
  assign FRAME_DONE   = frame_done_q;
  assign ERR_UNDERRUN = err_underrun_q;
  assign ERR_OVERSIZE = err_oversize_q;
  assign BUSY         = (state_q != ST_IDLE);

endmodule
